// File: rtl/cpu_phase_controller.sv
// cpu_phase_controller: eight-phase fetch/execute sequencer decoding opcode into datapath strobes.
// Define SINGLE_STEP_EN to add a step input that holds phase 0 until step is sampled high.
module cpu_phase_controller #(
  parameter int NPHASE      = 8,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;
  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND = 3'b011,
                         XOR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;
  phase_t ph, ph_d;
  logic   halted, halted_d, hold, run, alu, is_hlt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ph     <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      ph     <= ph_d;
      halted <= halted_d;
    end
  always_comb begin
    hold = halted;
`ifdef SINGLE_STEP_EN
    hold = halted || (ph == INST_ADDR && !step);
`endif
    is_hlt   = opcode == HLT;
    ph_d     = hold ? ph : (ph == phase_t'(3'(NPHASE - 1))) ? INST_ADDR : phase_t'(ph + 3'd1);
    halted_d = halted || (HALT_STICKY && ph == OP_ADDR && is_hlt);
    run      = !halted;
    alu      = opcode inside {ADD, AND, XOR, LDA};
    sel      = run && ph <= IDLE;
    rd       = run && ((ph >= INST_FETCH && ph <= IDLE) || (ph >= OP_FETCH && alu));
    ld_ir    = run && (ph == INST_LOAD || ph == IDLE);
    inc_pc   = run && (ph == OP_ADDR || (ph == ALU_OP && opcode == SKZ && zero) || (ph == STORE && opcode == JMP));
    ld_pc    = run && ph >= ALU_OP && opcode == JMP;
    ld_ac    = run && ph == STORE && alu;
    wr       = run && ph == STORE && opcode == STO;
    data_e   = run && ph >= ALU_OP && opcode == STO;
    halt     = halted || (ph == OP_ADDR && is_hlt);
    phase    = ph;
  end
endmodule

// File: tb/tb_cpu_phase_controller.sv
// tb_cpu_phase_controller: directed and random instruction sequences checked against a phase-table model.
module tb_cpu_phase_controller;
  logic       clock = 1'b0, reset = 1'b1, zero = 1'b0, step = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [2:0] phase;
  int         vectors = 0, miscompares = 0;
  int         mph = 0;
  bit         mhalt = 1'b0;

  cpu_phase_controller dut (
    .clock(clock), .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .zero(zero), .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected {sel,rd,wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt} straight from the phase table.
  function automatic logic [8:0] expect_out(int p, logic [2:0] op, logic z, bit h);
    logic s, r, w, li, ip, lp, la, de, hl;
    bit alu, sto, jmp, skz;
    alu = op >= 3'd2 && op <= 3'd5;
    sto = op == 3'd6;
    jmp = op == 3'd7;
    skz = op == 3'd1;
    {s, r, w, li, ip, lp, la, de, hl} = '0;
    if (h) return 9'b0_0000_0001;
    case (p)
      0: s = 1;
      1: begin s = 1; r = 1; end
      2, 3: begin s = 1; r = 1; li = 1; end
      4: begin ip = 1; hl = op == 3'd0; end
      5: r = alu;
      6: begin r = alu; ip = skz && z; lp = jmp; de = sto; end
      7: begin r = alu; la = alu; ip = jmp; lp = jmp; w = sto; de = sto; end
      default: ;
    endcase
    return {s, r, w, li, ip, lp, la, de, hl};
  endfunction

  task automatic check(input string tag);
    logic [8:0] obs, exp;
    obs = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt};
    exp = expect_out(mph, opcode, zero, mhalt);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s strobes ph=%0d op=%b: observed %b expected %b", tag, mph, opcode, obs, exp);
    end
    vectors++;
    assert (phase === 3'(mph)) else begin
      miscompares++;
      $error("FAIL %s phase: observed %0d expected %0d", tag, phase, mph);
    end
  endtask

  task automatic advance_model();
    bit held;
    held = mhalt;
`ifdef SINGLE_STEP_EN
    held = held || (mph == 0 && !step);
`endif
    if (!held) begin
      if (mph == 4 && opcode == 3'd0) begin
        mhalt = 1'b1;
        mph = 5;
      end else mph = (mph + 1) % 8;
    end
  endtask

  task automatic tick(input logic [2:0] op, input logic z, input string tag);
    @(negedge clock);
    opcode = op;
    zero = z;
    #1 check(tag);
    @(posedge clock);
    advance_model();
  endtask

  // zmode: 0/1 fixed zero level, 2 random every cycle, 3 random except fixed 1 in phase 6
  task automatic run_instr(input logic [2:0] op, input int zmode, input string tag);
    logic [2:0] o;
    logic z;
    for (int i = 0; i < 8; i++) begin
      o = (mph >= 4) ? op : 3'($urandom);
      z = (zmode == 2 || (zmode == 3 && mph != 6)) ? 1'($urandom) : (zmode == 3 ? 1'b1 : 1'(zmode));
      tick(o, z, tag);
    end
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    mph = 0;
    mhalt = 1'b0;
    #1 check(tag);
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 check("rst_hold");
    #1 reset = 1'b0;
    run_instr(3'b101, 2, "lda");
    run_instr(3'b110, 2, "sto");
    run_instr(3'b001, 1, "skz_z1");
    run_instr(3'b001, 0, "skz_z0");
    run_instr(3'b001, 3, "skz_zmix");
    run_instr(3'b111, 2, "jmp");
    run_instr(3'b010, 2, "add");
    run_instr(3'b011, 2, "and");
    run_instr(3'b100, 2, "xor");
    for (int n = 0; n < 30; n++) run_instr(3'($urandom_range(1, 7)), 2, "rand");
    for (int i = 0; i < 7; i++) tick(mph >= 4 ? 3'b110 : 3'($urandom), 1'($urandom), "sto_mid");
    @(negedge clock);
    opcode = 3'b110;
    #1 check("sto_p7");
    do_reset("rst_mid_wr");
    run_instr(3'b101, 2, "post_rst");
    run_instr(3'b000, 2, "hlt");
    for (int i = 0; i < 22; i++) tick(3'($urandom), 1'($urandom), "halted");
    do_reset("rst_halt");
    run_instr(3'b110, 2, "post_halt");
`ifdef SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 10; i++) tick(3'($urandom), 1'($urandom), "step_hold");
    step = 1'b1;
    tick(3'($urandom), 1'($urandom), "step_pulse");
    step = 1'b0;
    run_instr(3'b101, 2, "step_run");
    for (int i = 0; i < 4; i++) tick(3'($urandom), 1'($urandom), "step_rehold");
    step = 1'b1;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
